product_info_reader: RTL
========================

Name: product_info_reader

Overview:
- Avalon-MM read initiator that fetches the product-information register bank: a 4-word, read-only slave with active-low strobes and a fixed read latency.
- On start, or automatically after reset, it reads words 0..NUM_WORDS-1 in sequence and latches them.
- It then flags completion and compares word 0 with the expected product ID.
- It sits in the system-management logic and feeds the board-ID and version status to local control logic without involving the soft CPU.

Parameters:
- DATA_W, 32, readdata width.
- ADDR_W, 2, slave word-address width.
- NUM_WORDS, 4, words read per scan (≤ 2**ADDR_W).
- READ_LATENCY, 1, cycles from strobe to valid readdata (legal range 1..4).
- AUTO_START, 1, when 1 a scan starts automatically in the first cycle after reset release.
- EXPECTED_ID, 32'h0000_0000, value that word 0 must equal for id_match.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle scan request.
- chipselect_n  out  1  slave select, active low.
- read_n  out  1  read strobe, active low.
- av_address  out  ADDR_W  slave word address.
- av_data_read  in  DATA_W  slave readdata.
- info_words  out  DATA_W*NUM_WORDS  captured words; word k is at bits [k*DATA_W +: DATA_W].
- busy  out  1  scan in progress.
- valid  out  1  info_words are complete and current.
- done  out  1  single-cycle pulse when a scan finishes.
- id_match  out  1  word 0 == EXPECTED_ID; only meaningful while valid is high.

Behaviour:
- Reset is asynchronous and active-low on reset_n; clk is the only clock.
- While reset_n=0:
  - chipselect_n=1, read_n=1, av_address=0.
  - info_words=0, busy=0, valid=0, done=0, id_match=0.
  - Internal state is IDLE and the word index is 0.
- FSM states are IDLE, ISSUE, WAIT, CAPTURE, FINISH.
- IDLE:
  - Moves to ISSUE on start=1, or on the first post-reset cycle when AUTO_START=1.
  - On leaving IDLE: busy←1, valid←0, word index←0.
  - info_words keep their old values until each word is overwritten.
- ISSUE, exactly one cycle:
  - chipselect_n=0, read_n=0, av_address=index.
  - Both strobes are registered outputs and are high in every other state.
  - av_address holds its value until the next ISSUE.
  - Moves to WAIT.
- WAIT:
  - A latency counter counts READ_LATENCY-1 cycles; for READ_LATENCY=1 WAIT is skipped and ISSUE goes directly to CAPTURE.
  - Net effect: av_data_read is sampled on the clock edge that ends cycle T+READ_LATENCY, where T is the ISSUE cycle.
- CAPTURE:
  - info_words[index] ← av_data_read.
  - If index == NUM_WORDS-1, move to FINISH; otherwise index++ and move to ISSUE.
  - Index arithmetic is ADDR_W+1 bits wide, so NUM_WORDS = 2**ADDR_W never wraps early.
- FINISH, one cycle:
  - done=1, valid←1, busy←0.
  - id_match ← (info_words[0] == EXPECTED_ID).
  - Moves to IDLE.
- Cycles per word: READ_LATENCY+1. For start in cycle S, strobes fall in cycles S+1+k*(READ_LATENCY+1).
  - Defaults (READ_LATENCY=1, NUM_WORDS=4): strobes at S+1, S+3, S+5, S+7; done=1 and valid=1 from cycle S+9.
- start while busy=1 is ignored; no queuing.
- start in the FINISH cycle is also ignored. start in the first IDLE cycle after FINISH is accepted.
- A start that coincides with the AUTO_START cycle produces a single scan.
- Once set, valid stays high until the next scan starts or reset asserts.
- Asserting reset mid-scan aborts immediately to reset values; there is no partial valid.
- The slave has no waitrequest; readdata is trusted at the fixed latency and no timeout is needed.

Decomposition:
- Shared package (sysmgmt_pkg) holds:
  - the FSM state enum (IDLE, ISSUE, WAIT, CAPTURE, FINISH);
  - localparams for default READ_LATENCY and the product-info word count;
  - word-index constants for the ID, version, date and serial words (0..3).
- No sub-module is warranted. The latency counter and FSM live in one module (~150-200 lines).

Test Plan:
- AUTO_START=1; slave returns 32'hA5A5_0001, 0002, 0003, 0004:
  - strobes low in cycles 1, 3, 5, 7 after reset release, with av_address=0, 1, 2, 3;
  - done pulses at cycle 9;
  - info_words = {0004, 0003, 0002, A5A5_0001}; valid=1.
- EXPECTED_ID=32'hA5A5_0001 and matching word 0 -> id_match=1. Word 0 = 32'hDEAD_BEEF -> id_match=0, valid still 1.
- READ_LATENCY=3, AUTO_START=0, start at cycle 10:
  - strobes at cycles 11, 15, 19, 23;
  - each word sampled exactly 3 cycles after its strobe;
  - a decoy value on av_data_read in cycles T+1 and T+2 is never captured.
- start pulsed during cycles 12 and 16 of an active scan -> exactly one done and no extra strobes. A second start after done -> valid drops, rescan, new values captured.
- reset_n asserted at the cycle of the third strobe -> all outputs to reset values asynchronously. After release, a fresh scan completes normally with 4 strobes.
- Strobe integrity check on every run: chipselect_n and read_n are always equal, each low for exactly one cycle per word, and never low while busy=0.

Source files
------------

// File: rtl/sysmgmt_pkg.sv
// Shared system-management definitions: product-info reader FSM encoding,
// default read timing and the layout of the product-information register bank.
package sysmgmt_pkg;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StIssue   = 3'd1;
  localparam logic [2:0] StWait    = 3'd2;
  localparam logic [2:0] StCapture = 3'd3;
  localparam logic [2:0] StFinish  = 3'd4;

  localparam int unsigned DefaultReadLatency = 1;
  localparam int unsigned ProdInfoWords      = 4;

  localparam int unsigned WordId      = 0;
  localparam int unsigned WordVersion = 1;
  localparam int unsigned WordDate    = 2;
  localparam int unsigned WordSerial  = 3;

endpackage

// File: rtl/product_info_reader.sv
// Avalon-MM read initiator that scans the product-information bank once per
// request (or automatically after reset) and reports the words plus an ID match.
module product_info_reader
  import sysmgmt_pkg::*;
#(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       ADDR_W       = 2,
  parameter int unsigned       NUM_WORDS    = ProdInfoWords,
  parameter int unsigned       READ_LATENCY = DefaultReadLatency,
  parameter bit                AUTO_START   = 1'b1,
  parameter logic [DATA_W-1:0] EXPECTED_ID  = '0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  output logic                        chipselect_n,
  output logic                        read_n,
  output logic [ADDR_W-1:0]           av_address,
  input  logic [DATA_W-1:0]           av_data_read,
  output logic [DATA_W*NUM_WORDS-1:0] info_words,
  output logic                        busy,
  output logic                        valid,
  output logic                        done,
  output logic                        id_match
);

  // One extra index bit so a full 2**ADDR_W scan reaches its last word without wrapping.
  localparam int unsigned          IdxW    = ADDR_W + 1;
  localparam logic [IdxW-1:0]      LastIdx = IdxW'(NUM_WORDS - 1);
  localparam logic [1:0]           LatLast = (READ_LATENCY >= 2) ? 2'(READ_LATENCY - 2) : 2'd0;

  logic [2:0]                         state_q, state_d;
  logic [IdxW-1:0]                    idx_q, idx_d;
  logic [1:0]                         lat_q, lat_d;
  logic                               first_q;
  logic                               strobe_n_q;
  logic [ADDR_W-1:0]                  addr_q;
  logic [NUM_WORDS-1:0][DATA_W-1:0]   words_q, words_d;
  logic                               busy_q, busy_d;
  logic                               valid_q, valid_d;
  logic                               done_q;
  logic                               id_q, id_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    words_d = words_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    id_d    = id_q;
    unique case (state_q)
      StIdle: begin
        if (start || (AUTO_START && first_q)) begin
          state_d = StIssue;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          idx_d   = '0;
        end
      end
      StIssue: begin
        lat_d   = '0;
        state_d = (READ_LATENCY <= 1) ? StCapture : StWait;
      end
      StWait: begin
        if (lat_q == LatLast) begin
          state_d = StCapture;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      StCapture: begin
        for (int unsigned k = 0; k < NUM_WORDS; k++) begin
          if (idx_q == IdxW'(k)) words_d[k] = av_data_read;
        end
        if (idx_q == LastIdx) begin
          // Status flags switch on entry so they are already visible in the done cycle.
          state_d = StFinish;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          id_d    = (words_d[0] == EXPECTED_ID);
        end else begin
          idx_d   = idx_q + IdxW'(1);
          state_d = StIssue;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      lat_q      <= '0;
      first_q    <= 1'b1;
      strobe_n_q <= 1'b1;
      addr_q     <= '0;
      words_q    <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      id_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lat_q      <= lat_d;
      first_q    <= 1'b0;
      strobe_n_q <= (state_d != StIssue);
      if (state_d == StIssue) addr_q <= idx_d[ADDR_W-1:0];
      words_q    <= words_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      done_q     <= (state_d == StFinish);
      id_q       <= id_d;
    end
  end

  assign chipselect_n = strobe_n_q;
  assign read_n       = strobe_n_q;
  assign av_address   = addr_q;
  assign info_words   = words_q;
  assign busy         = busy_q;
  assign valid        = valid_q;
  assign done         = done_q;
  assign id_match     = id_q;

endmodule
